pb_press_classifier: RTL and testbench

- Sits directly downstream of the pushbutton debouncer.
- Consumes the clean, level-type debounced button signal and turns it into single-cycle event pulses for the stopwatch control FSM:
  - press and release edges
  - short-press classification (start/stop)
  - long-press detection (clear)
  - auto-repeat while held
- One instance per button, all in the system clock domain.

---
 rtl/pb_ctrl_pkg.sv | 18 +
 rtl/pb_edge_detect.sv | 24 ++
 rtl/pb_press_classifier.sv | 142 ++++++++++++++
 tb/tb_pb_press_classifier.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pb_ctrl_pkg.sv
// Shared types and helpers for pushbutton consumers in the stopwatch control path.
package pb_ctrl_pkg;

    typedef enum logic [1:0] {
        PB_IDLE    = 2'd0,
        PB_PRESSED = 2'd1,
        PB_LONG    = 2'd2
    } pb_state_t;

    function automatic int ms_to_cycles(input int ms, input int clkfreq);
        return (ms * clkfreq) / 1000;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// Rise/fall detector for a clean level input; previous sample resets high so a
// level already asserted at reset release is not mistaken for a new edge.
module pb_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_i,
    output logic rise_o,
    output logic fall_o
);

    logic pb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_q <= 1'b1;
        end else begin
            pb_q <= pb_i;
        end
    end

    assign rise_o = pb_i & ~pb_q;
    assign fall_o = ~pb_i & pb_q;

endmodule

// File: rtl/pb_press_classifier.sv
// Turns a debounced button level into single-cycle press/release/short/long/repeat
// events for the stopwatch control FSM. All outputs are registered.
module pb_press_classifier
    import pb_ctrl_pkg::*;
#(
    parameter int CLKFREQ   = 1000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_debounced,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] dbg_state
);

    localparam int LONG_CYC   = ms_to_cycles(LONG_MS, CLKFREQ);
    localparam int REPEAT_CYC = ms_to_cycles(REPEAT_MS, CLKFREQ);
    localparam int MAX_CYC    = max_int(LONG_CYC, REPEAT_CYC);
    localparam int CTRBITS    = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CTRBITS-1:0] LONG_LAST   = CTRBITS'(LONG_CYC - 1);
    localparam logic [CTRBITS-1:0] REPEAT_LAST = CTRBITS'(REPEAT_CYC - 1);

    if (LONG_CYC < 2) begin : g_long_too_short
        $error("pb_press_classifier: LONG_CYC must be at least 2");
    end
    if (REPEAT_CYC < 2) begin : g_repeat_too_short
        $error("pb_press_classifier: REPEAT_CYC must be at least 2");
    end

    logic rise;
    logic fall;

    pb_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .pb_i   (pb_debounced),
        .rise_o (rise),
        .fall_o (fall)
    );

    pb_state_t          state_q, state_d;
    logic [CTRBITS-1:0] count_q, count_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PB_IDLE;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    // A fall always takes priority, so a release landing on a threshold edge
    // is reported as a plain release and never as long/repeat.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            PB_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    state_d = PB_PRESSED;
                    count_d = '0;
                end
            end
            PB_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    state_d   = PB_IDLE;
                    count_d   = '0;
                end else if (count_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = PB_LONG;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            PB_LONG: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = PB_IDLE;
                    count_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (count_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = PB_IDLE;
                count_d = '0;
            end
        endcase
        held_d = (state_d != PB_IDLE);
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pb_press_classifier.sv
// Directed bench for pb_press_classifier with repeat enabled and disabled
// instances driven by the same button level.
module tb_pb_press_classifier;

    localparam int LONG_CYC   = 10;
    localparam int REPEAT_CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pb    = 1'b0;

    logic r_press, r_release, r_short, r_long, r_repeat, r_held;
    logic n_press, n_release, n_short, n_long, n_repeat, n_held;
    logic [1:0] r_dbg, n_dbg;
    logic [5:0] obs_r, obs_n;

    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pb_press_classifier #(
        .CLKFREQ(1000), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(1)
    ) dut_rep (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_debounced  (pb),
        .press_pulse   (r_press),
        .release_pulse (r_release),
        .short_pulse   (r_short),
        .long_pulse    (r_long),
        .repeat_pulse  (r_repeat),
        .held          (r_held),
        .dbg_state     (r_dbg)
    );

    pb_press_classifier #(
        .CLKFREQ(1000), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(0)
    ) dut_norep (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_debounced  (pb),
        .press_pulse   (n_press),
        .release_pulse (n_release),
        .short_pulse   (n_short),
        .long_pulse    (n_long),
        .repeat_pulse  (n_repeat),
        .held          (n_held),
        .dbg_state     (n_dbg)
    );

    assign obs_r = {r_press, r_release, r_short, r_long, r_repeat, r_held};
    assign obs_n = {n_press, n_release, n_short, n_long, n_repeat, n_held};

    // Expected {press,release,short,long,repeat,held} k cycles after the edge
    // that first samples the button high, for a press lasting h cycles.
    function automatic logic [5:0] ev(input int k, input int h, input bit ren);
        logic p, rl, sh, lg, rp, hd;
        p  = (k == 0);
        rl = (k == h);
        sh = (k == h) && (h <= LONG_CYC);
        lg = (k == LONG_CYC) && (h > LONG_CYC);
        rp = ren && (k > LONG_CYC) && (k < h) && (((k - LONG_CYC) % REPEAT_CYC) == 0);
        hd = (k < h);
        return {p, rl, sh, lg, rp, hd};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step(input logic pb_v, input logic [11:0] e, input string tag);
        @(negedge clk);
        pb = pb_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag, {obs_n, obs_r}, exp_q.pop_front());
    endtask

    task automatic press(input int h, input int tail, input string tag);
        for (int k = 0; k <= h; k++) begin
            step(k < h, {ev(k, h, 1'b0), ev(k, h, 1'b1)}, tag);
        end
        for (int k = 0; k < tail; k++) begin
            step(1'b0, 12'b0, tag);
        end
    endtask

    initial begin
        #1;
        check("reset_outputs", {obs_n, obs_r}, 12'b0);
        check("reset_state", {8'b0, n_dbg, r_dbg}, 12'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_low", {obs_n, obs_r}, 12'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) step(1'b0, 12'b0, "idle_after_reset");

        press(5,  3, "short_press");
        press(25, 3, "long_repeat");
        press(10, 3, "boundary_10");
        press(11, 3, "long_then_release");
        press(14, 3, "fall_on_repeat");
        press(30, 3, "hold_30");
        press(2,  2, "min_press");

        // Reset asserted while the button is held, which stays held afterwards.
        @(negedge clk);
        pb    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_with_pb", {obs_n, obs_r}, 12'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 12'b0, "held_in_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step(1'b1, 12'b0, "held_after_reset");
        for (int k = 0; k < 2; k++) step(1'b0, 12'b0, "release_after_reset");
        press(3, 3, "repress_after_reset");

        // Reset six cycles into a hold: outputs clear at once, no release follows.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, {ev(k, 100, 1'b0), ev(k, 100, 1'b1)}, "pre_mid_reset");
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mid_reset", {obs_n, obs_r}, 12'b0);
        check("async_mid_state", {8'b0, n_dbg, r_dbg}, 12'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 12'b0, "mid_reset_low");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, 12'b0, "mid_reset_still_held");
        for (int k = 0; k < 3; k++) step(1'b0, 12'b0, "no_release_after_reset");
        press(5, 2, "recover_press");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
